// File: rtl/fpu_ss_xif_mem_responder_pkg.sv
// rtl/fpu_ss_xif_mem_responder_pkg.sv - fpu_ss_pkg: XIF mem responder types and lane helpers
package fpu_ss_pkg;

    localparam int unsigned XIF_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0] id;
        logic                    we;
        mem_size_e               size;
        logic [1:0]              offset;
    } mem_rsp_meta_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ERR  = 2'd2
    } responder_state_e;

    // Lanes touched by an access; lanes past the word boundary fall off the top.
    function automatic logic [3:0] byte_enables(mem_size_e size, logic [1:0] off);
        logic [3:0] base;
        case (size)
            MEM_BYTE: base = 4'b0001;
            MEM_HALF: base = 4'b0011;
            default:  base = 4'b1111;
        endcase
        return base << off;
    endfunction

    function automatic logic is_misaligned(mem_size_e size, logic [1:0] off);
        logic mis;
        case (size)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = off[0];
            default:  mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    // Bring the addressed lanes down to bit 0 and zero-extend to the access size.
    function automatic logic [31:0] extract_rdata(logic [31:0] rdata, mem_size_e size, logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {off, 3'b000};
        case (size)
            MEM_BYTE: res = {24'h0, sh[7:0]};
            MEM_HALF: res = {16'h0, sh[15:0]};
            default:  res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fpu_ss_xif_mem_responder_if.sv
// rtl/fpu_ss_xif_mem_responder_if.sv - XIF mem port plus OBI data bus bundle
interface fpu_ss_xif_mem_responder_if #(
    parameter int unsigned ID_WIDTH = 4
);
    logic                x_mem_valid;
    logic                x_mem_ready;
    logic [ID_WIDTH-1:0] x_mem_req_id;
    logic [31:0]         x_mem_req_addr;
    logic                x_mem_req_we;
    logic [1:0]          x_mem_req_size;
    logic [31:0]         x_mem_req_wdata;
    logic                x_mem_result_valid;
    logic [ID_WIDTH-1:0] x_mem_result_id;
    logic [31:0]         x_mem_result_rdata;
    logic                x_mem_result_err;
    logic                data_req;
    logic                data_gnt;
    logic [31:0]         data_addr;
    logic                data_we;
    logic [3:0]          data_be;
    logic [31:0]         data_wdata;
    logic                data_rvalid;
    logic [31:0]         data_rdata;
    logic                data_err;

    modport slave (
        input  x_mem_valid, x_mem_req_id, x_mem_req_addr, x_mem_req_we, x_mem_req_size, x_mem_req_wdata,
        output x_mem_ready, x_mem_result_valid, x_mem_result_id, x_mem_result_rdata, x_mem_result_err,
        output data_req, data_addr, data_we, data_be, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err
    );

    modport master (
        output x_mem_valid, x_mem_req_id, x_mem_req_addr, x_mem_req_we, x_mem_req_size, x_mem_req_wdata,
        input  x_mem_ready, x_mem_result_valid, x_mem_result_id, x_mem_result_rdata, x_mem_result_err,
        input  data_req, data_addr, data_we, data_be, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err
    );
endinterface

// File: rtl/fpu_ss_mem_rsp_fifo.sv
// rtl/fpu_ss_mem_rsp_fifo.sv - in-order metadata FIFO for granted bus transactions
module fpu_ss_mem_rsp_fifo
    import fpu_ss_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  mem_rsp_meta_t push_data,
    input  logic          pop,
    output mem_rsp_meta_t pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    mem_rsp_meta_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fpu_ss_xif_mem_responder.sv
// rtl/fpu_ss_xif_mem_responder.sv - XIF mem request responder on OBI; FPU_SS_MEM_MISALIGN_CHECK_EN enables the alignment error path
module fpu_ss_xif_mem_responder
    import fpu_ss_pkg::*;
#(
    parameter int unsigned ID_WIDTH        = XIF_ID_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input logic                      clk_i,
    input logic                      rst_i,
    fpu_ss_xif_mem_responder_if.slave xif
);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    responder_state_e state_q;
    responder_state_e state_d;
    mem_rsp_meta_t    req_meta_q;
    mem_rsp_meta_t    head;
    logic [CW-1:0]    count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             grant;
    logic             handshake;
    logic             ready;
    logic             req_misaligned;
    logic             rsp_pop;
    logic             seen_gnt_q;
    logic [1:0]       req_off;
    mem_size_e        req_size;

    assign req_off  = xif.x_mem_req_addr[1:0];
    assign req_size = mem_size_e'(xif.x_mem_req_size);
`ifdef FPU_SS_MEM_MISALIGN_CHECK_EN
    assign req_misaligned = is_misaligned(req_size, req_off);
`else
    assign req_misaligned = 1'b0;
`endif
    assign grant           = (state_q == ST_REQ) && xif.data_gnt;
    assign rsp_pop         = xif.data_rvalid && !fifo_empty;
    assign xif.x_mem_ready = ready;

    fpu_ss_mem_rsp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (grant),
        .push_data (req_meta_q),
        .pop       (rsp_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Acceptance and next state; a grant frees the request slot for a back-to-back handshake.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        if (((state_q == ST_IDLE) || grant) && ((32'(count) + 32'(grant)) < MAX_OUTSTANDING))
            ready = 1'b1;
        if (req_misaligned && !((state_q == ST_IDLE) && (count == '0)))
            ready = 1'b0;
        if (rst_i)
            ready = 1'b0;
        handshake = xif.x_mem_valid && ready;
        case (state_q)
            ST_IDLE: if (handshake) state_d = req_misaligned ? ST_ERR : ST_REQ;
            ST_REQ:  if (grant) state_d = handshake ? ST_REQ : ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus request registers: loaded on an accepted request, held until granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xif.data_req   <= 1'b0;
            xif.data_addr  <= '0;
            xif.data_we    <= 1'b0;
            xif.data_be    <= '0;
            xif.data_wdata <= '0;
            req_meta_q     <= '0;
        end else if (handshake && !req_misaligned) begin
            xif.data_req   <= 1'b1;
            xif.data_addr  <= {xif.x_mem_req_addr[31:2], 2'b00};
            xif.data_we    <= xif.x_mem_req_we;
            xif.data_be    <= byte_enables(req_size, req_off);
            xif.data_wdata <= xif.x_mem_req_wdata << {req_off, 3'b000};
            req_meta_q     <= '{id: XIF_ID_WIDTH'(xif.x_mem_req_id), we: xif.x_mem_req_we,
                                size: req_size, offset: req_off};
        end else if (grant) begin
            xif.data_req   <= 1'b0;
        end
    end

    // Result register: one-cycle pulse per bus response or per rejected misaligned request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xif.x_mem_result_valid <= 1'b0;
            xif.x_mem_result_id    <= '0;
            xif.x_mem_result_rdata <= '0;
            xif.x_mem_result_err   <= 1'b0;
        end else begin
            xif.x_mem_result_valid <= 1'b0;
            if (rsp_pop) begin
                xif.x_mem_result_valid <= 1'b1;
                xif.x_mem_result_id    <= ID_WIDTH'(head.id);
                xif.x_mem_result_err   <= xif.data_err;
                xif.x_mem_result_rdata <= head.we ? '0 : extract_rdata(xif.data_rdata, head.size, head.offset);
            end else if (handshake && req_misaligned) begin
                xif.x_mem_result_valid <= 1'b1;
                xif.x_mem_result_id    <= xif.x_mem_req_id;
                xif.x_mem_result_err   <= 1'b1;
                xif.x_mem_result_rdata <= '0;
            end
        end
    end

    // Until the first grant after reset, stray responses belong to pre-reset traffic and are dropped quietly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      seen_gnt_q <= 1'b0;
        else if (grant) seen_gnt_q <= 1'b1;
    end

`ifndef SYNTHESIS
    // Protocol checks: no response without a matching grant, no grant into a full FIFO.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(xif.data_rvalid && fifo_empty && seen_gnt_q))
                else $error("data_rvalid with no outstanding transaction");
            assert (!(grant && fifo_full))
                else $error("grant with response FIFO full");
        end
    end
`endif
endmodule

// File: tb/tb_fpu_ss_xif_mem_responder.sv
// tb/tb_fpu_ss_xif_mem_responder.sv - self-checking bench with queue-based reference model
module tb_fpu_ss_xif_mem_responder;
    import fpu_ss_pkg::*;

    localparam int MAXO = 2;
`ifdef FPU_SS_MEM_MISALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_ss_xif_mem_responder_if #(.ID_WIDTH(4)) xif ();

    fpu_ss_xif_mem_responder #(.ID_WIDTH(4), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .xif   (xif)
    );

    typedef struct {
        int          id;
        bit          we;
        int          size;
        int          off;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        to_bus[$];
    req_t        outst[$];
    bit          res_pend;
    int          res_id;
    logic [31:0] res_rdata;
    bit          res_err;
    bit          err_busy;
    bit          accepted;
    bit          auto_mode;
    int          gnt_pct;
    int          rv_pct;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] size_mask(int size);
        return (size == 0) ? 32'hFF : (size == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [3:0] lane_mask(int size, int off);
        int          nbytes;
        logic [7:0]  m;
        nbytes = 1 << size;
        m = 8'(((1 << nbytes) - 1) << off);
        return m[3:0];
    endfunction

    function automatic bit misaligned(int size, int off);
        return CHK_EN && ((off % (1 << size)) != 0);
    endfunction

    task automatic check_outputs();
        int busy;
        bit exp_ready;
        if (res_pend) begin
            chk("res_valid", 32'(xif.x_mem_result_valid), 32'd1);
            chk("res_id", 32'(xif.x_mem_result_id), 32'(res_id));
            chk("res_rdata", xif.x_mem_result_rdata, res_rdata);
            chk("res_err", 32'(xif.x_mem_result_err), 32'(res_err));
        end else begin
            chk("res_valid_quiet", 32'(xif.x_mem_result_valid), 32'd0);
        end
        chk("data_req", 32'(xif.data_req), 32'(to_bus.size() != 0));
        if (to_bus.size() != 0) begin
            chk("data_addr", xif.data_addr, to_bus[0].addr & 32'hFFFF_FFFC);
            chk("data_we", 32'(xif.data_we), 32'(to_bus[0].we));
            chk("data_be", 32'(xif.data_be), 32'(lane_mask(to_bus[0].size, to_bus[0].off)));
            chk("data_wdata", xif.data_wdata, to_bus[0].wdata << (8 * to_bus[0].off));
        end
        busy = outst.size() + to_bus.size();
        exp_ready = !err_busy && (to_bus.size() == 0 || xif.data_gnt) && (busy < MAXO)
                    && (!misaligned(int'(xif.x_mem_req_size), int'(xif.x_mem_req_addr[1:0])) || busy == 0);
        chk("ready", 32'(xif.x_mem_ready), 32'(exp_ready));
    endtask

    task automatic cycle();
        logic        s_valid, s_ready, s_gnt, s_rvalid, s_err;
        logic [31:0] s_rdata;
        req_t        r;
        if (auto_mode) begin
            xif.data_gnt    = ($urandom_range(99) < gnt_pct);
            xif.data_rvalid = (outst.size() != 0) && ($urandom_range(99) < rv_pct);
            xif.data_rdata  = $urandom;
            xif.data_err    = ($urandom_range(9) == 0);
        end
        @(negedge clk);
        check_outputs();
        s_valid  = xif.x_mem_valid;
        s_ready  = xif.x_mem_ready;
        s_gnt    = xif.data_gnt;
        s_rvalid = xif.data_rvalid;
        s_rdata  = xif.data_rdata;
        s_err    = xif.data_err;
        r.id    = int'(xif.x_mem_req_id);
        r.we    = xif.x_mem_req_we;
        r.size  = int'(xif.x_mem_req_size);
        r.off   = int'(xif.x_mem_req_addr[1:0]);
        r.addr  = xif.x_mem_req_addr;
        r.wdata = xif.x_mem_req_wdata;
        @(posedge clk);
        res_pend = 1'b0;
        if (s_rvalid && outst.size() != 0) begin
            req_t h;
            h = outst.pop_front();
            res_pend  = 1'b1;
            res_id    = h.id;
            res_err   = s_err;
            res_rdata = h.we ? 32'h0 : ((s_rdata >> (8 * h.off)) & size_mask(h.size));
        end
        if (s_gnt && to_bus.size() != 0) outst.push_back(to_bus.pop_front());
        err_busy = 1'b0;
        accepted = 1'b0;
        if (s_valid && s_ready) begin
            accepted = 1'b1;
            if (misaligned(r.size, r.off)) begin
                res_pend  = 1'b1;
                res_id    = r.id;
                res_err   = 1'b1;
                res_rdata = 32'h0;
                err_busy  = 1'b1;
            end else begin
                to_bus.push_back(r);
            end
        end
        #1;
    endtask

    task automatic set_req(int id, logic [31:0] addr, bit we, int size, logic [31:0] wdata);
        xif.x_mem_valid     = 1'b1;
        xif.x_mem_req_id    = 4'(id);
        xif.x_mem_req_addr  = addr;
        xif.x_mem_req_we    = we;
        xif.x_mem_req_size  = 2'(size);
        xif.x_mem_req_wdata = wdata;
    endtask

    task automatic send(int id, logic [31:0] addr, bit we, int size, logic [31:0] wdata);
        int n;
        n = 0;
        set_req(id, addr, we, size, wdata);
        do begin
            cycle();
            n++;
        end while (!accepted && n < 40);
        chk("send_accepted", 32'(accepted), 32'd1);
        xif.x_mem_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        auto_mode = 1'b1;
        gnt_pct   = 100;
        rv_pct    = 100;
        while ((to_bus.size() + outst.size() != 0 || res_pend) && n < 100) begin
            cycle();
            n++;
        end
        chk("drain_in_time", 32'(n < 100), 32'd1);
        auto_mode       = 1'b0;
        xif.data_gnt    = 1'b0;
        xif.data_rvalid = 1'b0;
        xif.data_err    = 1'b0;
        cycle();
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_ready"}, 32'(xif.x_mem_ready), 32'd0);
        chk({tag, "_rvalid"}, 32'(xif.x_mem_result_valid), 32'd0);
        chk({tag, "_rid"}, 32'(xif.x_mem_result_id), 32'd0);
        chk({tag, "_rdata"}, xif.x_mem_result_rdata, 32'd0);
        chk({tag, "_rerr"}, 32'(xif.x_mem_result_err), 32'd0);
        chk({tag, "_req"}, 32'(xif.data_req), 32'd0);
        chk({tag, "_addr"}, xif.data_addr, 32'd0);
        chk({tag, "_we"}, 32'(xif.data_we), 32'd0);
        chk({tag, "_be"}, 32'(xif.data_be), 32'd0);
        chk({tag, "_wdata"}, xif.data_wdata, 32'd0);
    endtask

    task automatic model_reset();
        to_bus.delete();
        outst.delete();
        res_pend = 1'b0;
        err_busy = 1'b0;
        accepted = 1'b0;
    endtask

    initial begin
        auto_mode = 1'b0;
        gnt_pct = 0;
        rv_pct = 0;
        model_reset();
        xif.x_mem_valid = 1'b0;
        xif.x_mem_req_id = '0;
        xif.x_mem_req_addr = '0;
        xif.x_mem_req_we = 1'b0;
        xif.x_mem_req_size = '0;
        xif.x_mem_req_wdata = '0;
        xif.data_gnt = 1'b0;
        xif.data_rvalid = 1'b0;
        xif.data_rdata = '0;
        xif.data_err = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word load 0x100, grant in the request cycle, response two cycles after grant
        xif.data_gnt = 1'b1;
        send(3, 32'h100, 1'b0, 2, 32'h0);
        chk("t1_be", 32'(xif.data_be), 32'hF);
        cycle();
        xif.data_gnt = 1'b0;
        cycle();
        xif.data_rvalid = 1'b1;
        xif.data_rdata = 32'hDEAD_BEEF;
        cycle();
        xif.data_rvalid = 1'b0;
        chk("t1_res_valid", 32'(xif.x_mem_result_valid), 32'd1);
        chk("t1_res_id", 32'(xif.x_mem_result_id), 32'd3);
        chk("t1_res_rdata", xif.x_mem_result_rdata, 32'hDEAD_BEEF);
        chk("t1_res_err", 32'(xif.x_mem_result_err), 32'd0);
        cycle();

        // Byte store to 0x203
        xif.data_gnt = 1'b1;
        send(4, 32'h203, 1'b1, 0, 32'hAB);
        chk("t2_addr", xif.data_addr, 32'h200);
        chk("t2_be", 32'(xif.data_be), 32'h8);
        chk("t2_wdata", xif.data_wdata, 32'hAB00_0000);
        cycle();
        xif.data_gnt = 1'b0;
        xif.data_rvalid = 1'b1;
        xif.data_rdata = 32'h5555_AAAA;
        cycle();
        xif.data_rvalid = 1'b0;
        chk("t2_res_err", 32'(xif.x_mem_result_err), 32'd0);
        chk("t2_res_rdata", xif.x_mem_result_rdata, 32'd0);
        cycle();

        // Outstanding limit: third load waits for the first response
        xif.data_gnt = 1'b1;
        send(1, 32'h400, 1'b0, 2, 32'h0);
        send(2, 32'h404, 1'b0, 2, 32'h0);
        set_req(3, 32'h408, 1'b0, 2, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3_blocked", 32'(accepted), 32'd0);
        end
        xif.data_rvalid = 1'b1;
        xif.data_rdata = 32'h1111_1111;
        cycle();
        xif.data_rvalid = 1'b0;
        for (int i = 0; i < 10 && !accepted; i++) cycle();
        chk("t3_third_accepted", 32'(accepted), 32'd1);
        xif.x_mem_valid = 1'b0;
        drain();

        // Grant and response in the same cycle with one outstanding
        xif.data_gnt = 1'b1;
        send(6, 32'h500, 1'b0, 1, 32'h0);
        cycle();
        xif.data_gnt = 1'b0;
        send(7, 32'h504, 1'b0, 0, 32'h0);
        cycle();
        xif.data_gnt = 1'b1;
        xif.data_rvalid = 1'b1;
        xif.data_rdata = 32'hCAFE_F00D;
        cycle();
        xif.data_gnt = 1'b0;
        xif.data_rvalid = 1'b0;
        set_req(8, 32'h508, 1'b0, 2, 32'h0);
        cycle();
        chk("t4_next_accepted", 32'(accepted), 32'd1);
        xif.x_mem_valid = 1'b0;
        drain();

        // Misaligned word load at 0x102
        xif.data_gnt = 1'b1;
        send(5, 32'h102, 1'b0, 2, 32'h0);
        if (CHK_EN) begin
            chk("t5_err_valid", 32'(xif.x_mem_result_valid), 32'd1);
            chk("t5_err_id", 32'(xif.x_mem_result_id), 32'd5);
            chk("t5_err_flag", 32'(xif.x_mem_result_err), 32'd1);
            chk("t5_no_req", 32'(xif.data_req), 32'd0);
            xif.data_gnt = 1'b0;
            cycle();
        end else begin
            chk("t5_be", 32'(xif.data_be), 32'hC);
            cycle();
            xif.data_gnt = 1'b0;
            xif.data_rvalid = 1'b1;
            xif.data_rdata = 32'h1234_5678;
            cycle();
            xif.data_rvalid = 1'b0;
            chk("t5_rdata", xif.x_mem_result_rdata, 32'h1234);
        end
        drain();

        // Randomised traffic against the reference model
        auto_mode = 1'b1;
        gnt_pct = 60;
        rv_pct = 45;
        xif.x_mem_valid = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!xif.x_mem_valid || accepted) begin
                if ($urandom_range(3) != 0)
                    set_req(int'($urandom_range(15)), $urandom, 1'($urandom_range(1)),
                            int'($urandom_range(2)), $urandom);
                else
                    xif.x_mem_valid = 1'b0;
            end
            cycle();
        end
        xif.x_mem_valid = 1'b0;
        drain();

        // Reset in REQ with one outstanding; a late response must vanish
        xif.data_gnt = 1'b1;
        send(9, 32'h600, 1'b0, 2, 32'h0);
        cycle();
        xif.data_gnt = 1'b0;
        send(10, 32'h604, 1'b1, 2, 32'h7777_0000);
        rst = 1'b1;
        #2;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        xif.data_rvalid = 1'b1;
        xif.data_rdata = 32'hBAD0_BAD0;
        cycle();
        xif.data_rvalid = 1'b0;
        chk("late_rvalid_dropped", 32'(xif.x_mem_result_valid), 32'd0);
        cycle();
        xif.data_gnt = 1'b1;
        send(11, 32'h700, 1'b0, 0, 32'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
